// File: rtl/des_key_schedule.sv
// des_key_schedule: sequential DES key schedule generator.
// Loads a 64-bit key, applies PC-1, then emits one 48-bit round subkey per
// valid/ready handshake. The order is K1..K16 for encrypt and K16..K1 for decrypt.
// Decrypt order is produced by right rotations, so the C/D halves never need
// to be pre-rotated by the full schedule.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start_i          load key_i/decrypt_i when idle
//   key_i[1:64]      DES key, bit 1 = MSB, bits 8,16,..,64 are parity bits
//   decrypt_i        0: K1 first, 1: K16 first
//   abort_i          abandon the current schedule (RUN only)
//   subkey_o[1:48]   PC-2 of the current C||D
//   subkey_valid_o   subkey_o valid
//   subkey_ready_i   consumer accepts subkey_o
//   round_o          DES round index of subkey_o (0 = K1 .. 15 = K16)
//   last_o           subkey_o is the final subkey of this schedule
//   busy_o           schedule in progress
//   parity_err_o     captured key had at least one even-parity byte
module des_key_schedule #(
  parameter bit          PARITY_CHECK = 1'b1,
  parameter int unsigned ROUNDS       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [1:64] key_i,
  input  logic        decrypt_i,
  input  logic        abort_i,
  output logic [1:48] subkey_o,
  output logic        subkey_valid_o,
  input  logic        subkey_ready_i,
  output logic [3:0]  round_o,
  output logic        last_o,
  output logic        busy_o,
  output logic        parity_err_o
);

  typedef enum logic {StIdle, StRun} state_e;

  localparam logic [3:0] LastStep = 4'(ROUNDS - 1);

  localparam int Pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int Pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] cd;
    for (int i = 0; i < 56; i++) cd[i+1] = k[Pc1Tab[i]];
    return cd;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:56] cd);
    logic [1:48] sk;
    for (int i = 0; i < 48; i++) sk[i+1] = cd[Pc2Tab[i]];
    return sk;
  endfunction

  // Shift table s[1..16]; idx is 0-based. Rounds 1, 2, 9 and 16 shift by one.
  function automatic logic shift_is_one(input logic [3:0] idx);
    return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic one);
    return one ? {x[2:28], x[1]} : {x[3:28], x[1:2]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic one);
    return one ? {x[28], x[1:27]} : {x[27:28], x[1:26]};
  endfunction

  // Odd parity expected per byte; any byte with an even count of ones flags.
  function automatic logic key_parity_err(input logic [1:64] k);
    logic err;
    logic p;
    err = 1'b0;
    for (int b = 0; b < 8; b++) begin
      p = 1'b0;
      for (int j = 1; j <= 8; j++) p = p ^ k[8*b+j];
      err = err | ~p;
    end
    return err;
  endfunction

  state_e      r_state, w_state;
  logic [1:28] r_c, r_d, w_c, w_d;
  logic [3:0]  r_round, w_round;
  logic [3:0]  r_step, w_step;
  logic        r_decrypt, w_decrypt;
  logic        r_perr, w_perr;

  logic [1:56] w_cd_load;
  logic        w_key_perr;
  logic [3:0]  w_shift_idx;
  logic        w_shift_one;
  logic        w_run;
  logic        w_last;

  assign w_cd_load  = pc1(key_i);
  assign w_key_perr = PARITY_CHECK ? key_parity_err(key_i) : 1'b0;
  assign w_run      = (r_state == StRun);
  assign w_last     = w_run && (r_step == LastStep);

  // Encrypt moves to round r+1 and uses its shift; decrypt undoes the shift
  // that produced the current round r.
  assign w_shift_idx = r_decrypt ? r_round : r_round + 4'd1;
  assign w_shift_one = shift_is_one(w_shift_idx);

  always_comb begin
    w_state   = r_state;
    w_c       = r_c;
    w_d       = r_d;
    w_round   = r_round;
    w_step    = r_step;
    w_decrypt = r_decrypt;
    w_perr    = r_perr;
    case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state   = StRun;
          w_decrypt = decrypt_i;
          w_perr    = w_key_perr;
          w_step    = 4'd0;
          if (decrypt_i) begin
            // Rotations total 28 per half, so C16||D16 equals C0||D0.
            w_c     = w_cd_load[1:28];
            w_d     = w_cd_load[29:56];
            w_round = 4'd15;
          end else begin
            w_c     = rotl(w_cd_load[1:28], 1'b1);
            w_d     = rotl(w_cd_load[29:56], 1'b1);
            w_round = 4'd0;
          end
        end
      end
      StRun: begin
        if (abort_i) begin
          w_state = StIdle;
        end else if (subkey_ready_i) begin
          if (w_last) begin
            w_state = StIdle;
          end else begin
            w_step = r_step + 4'd1;
            if (r_decrypt) begin
              w_c     = rotr(r_c, w_shift_one);
              w_d     = rotr(r_d, w_shift_one);
              w_round = r_round - 4'd1;
            end else begin
              w_c     = rotl(r_c, w_shift_one);
              w_d     = rotl(r_d, w_shift_one);
              w_round = r_round + 4'd1;
            end
          end
        end
      end
      default: w_state = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_c       <= '0;
      r_d       <= '0;
      r_round   <= '0;
      r_step    <= '0;
      r_decrypt <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_c       <= w_c;
      r_d       <= w_d;
      r_round   <= w_round;
      r_step    <= w_step;
      r_decrypt <= w_decrypt;
      r_perr    <= w_perr;
    end
  end

  assign subkey_o       = pc2({r_c, r_d});
  assign subkey_valid_o = w_run;
  assign busy_o         = w_run;
  assign round_o        = r_round;
  assign last_o         = w_last;
  assign parity_err_o   = r_perr;

endmodule
